// File: rtl/data_route_pkg.sv
// Shared widths and lane encodings for the packer and the downstream interconnect.
package data_route_pkg;

  localparam int DW_IN   = 256;
  localparam int F_BEATS = 6;
  localparam int G_BEATS = 5;
  localparam int H_BEATS = 1;

  localparam int F_W = F_BEATS * DW_IN;
  localparam int G_W = G_BEATS * DW_IN;
  localparam int H_W = H_BEATS * DW_IN;

  typedef enum logic [1:0] {
    TDEST_F   = 2'd0,
    TDEST_G   = 2'd1,
    TDEST_H   = 2'd2,
    TDEST_BAD = 2'd3
  } tdest_e;

  // Beat counter width; a single-beat lane still carries a 1-bit counter.
  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/data_packer_0_if.sv
// Stream bundle: one 256-bit input stream and the three packed output streams.
interface data_packer_0_if;
  import data_route_pkg::*;

  logic [DW_IN-1:0] s_in_tdata;
  logic [1:0]       s_in_tdest;
  logic             s_in_tlast;
  logic             s_in_tvalid;
  logic             s_in_tready;

  logic [F_W-1:0]   m_f_tdata;
  logic             m_f_tvalid;
  logic             m_f_tready;
  logic [G_W-1:0]   m_g_tdata;
  logic             m_g_tvalid;
  logic             m_g_tready;
  logic [H_W-1:0]   m_h_tdata;
  logic             m_h_tvalid;
  logic             m_h_tready;

  // Source side: drives input beats and accepts packed words.
  modport master (
    output s_in_tdata, s_in_tdest, s_in_tlast, s_in_tvalid,
    input  s_in_tready,
    input  m_f_tdata, m_f_tvalid, m_g_tdata, m_g_tvalid, m_h_tdata, m_h_tvalid,
    output m_f_tready, m_g_tready, m_h_tready
  );

  // Packer side.
  modport slave (
    input  s_in_tdata, s_in_tdest, s_in_tlast, s_in_tvalid,
    output s_in_tready,
    output m_f_tdata, m_f_tvalid, m_g_tdata, m_g_tvalid, m_h_tdata, m_h_tvalid,
    input  m_f_tready, m_g_tready, m_h_tready
  );

endinterface

// File: rtl/data_lane_packer.sv
// One packing lane: gathers BEATS input beats (beat 0 in the LSBs) into a
// wide word and presents it on an output valid/ready handshake.
module data_lane_packer
  import data_route_pkg::*;
#(
  parameter int DW_IN = 256,
  parameter int BEATS = 1,
  localparam int CNT_W = cnt_w(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW_IN-1:0]       beat_data,
  input  logic                   beat_we,
  input  logic                   beat_last,
  output logic                   ready,
  output logic [BEATS*DW_IN-1:0] acc,
  output logic                   vld,
  input  logic                   m_tready,
  output logic                   tlast_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt;
  logic             is_final;

  assign is_final  = (cnt == LAST_CNT);
  assign ready     = ~vld | m_tready;
  assign tlast_err = beat_we & (beat_last ^ is_final);

  // Beats are only presented while the held word is draining (ready), so a
  // slice write can never disturb data the consumer is still looking at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      vld <= 1'b0;
    end else begin
      if (vld && m_tready)
        vld <= 1'b0;
      if (beat_we) begin
        if (is_final) begin
          acc[cnt*DW_IN +: DW_IN] <= beat_data;
          cnt <= '0;
          vld <= 1'b1;
        end else if (beat_last) begin
          cnt <= '0;
        end else begin
          acc[cnt*DW_IN +: DW_IN] <= beat_data;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_packer_0.sv
// Steers each 256-bit input beat by tdest into the f/g/h packing lanes and
// keeps sticky flags for illegal tdest and misplaced tlast.
module data_packer_0
  import data_route_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  data_packer_0_if.slave  bus,
  output logic            err_tdest,
  output logic            err_tlast
);

  tdest_e dest;
  logic   accept;
  logic   rdy_f, rdy_g, rdy_h;
  logic   te_f, te_g, te_h;

  assign dest   = tdest_e'(bus.s_in_tdest);
  assign accept = bus.s_in_tvalid & bus.s_in_tready;

  // Illegal tdest is always accepted and dropped so it can never stall the source.
  always_comb begin
    bus.s_in_tready = 1'b1;
    case (dest)
      TDEST_F: bus.s_in_tready = rdy_f;
      TDEST_G: bus.s_in_tready = rdy_g;
      TDEST_H: bus.s_in_tready = rdy_h;
      default: bus.s_in_tready = 1'b1;
    endcase
  end

  data_lane_packer #(.DW_IN(DW_IN), .BEATS(F_BEATS)) u_lane_f (
    .clk       (clk),
    .rst       (rst),
    .beat_data (bus.s_in_tdata),
    .beat_we   (accept && dest == TDEST_F),
    .beat_last (bus.s_in_tlast),
    .ready     (rdy_f),
    .acc       (bus.m_f_tdata),
    .vld       (bus.m_f_tvalid),
    .m_tready  (bus.m_f_tready),
    .tlast_err (te_f)
  );

  data_lane_packer #(.DW_IN(DW_IN), .BEATS(G_BEATS)) u_lane_g (
    .clk       (clk),
    .rst       (rst),
    .beat_data (bus.s_in_tdata),
    .beat_we   (accept && dest == TDEST_G),
    .beat_last (bus.s_in_tlast),
    .ready     (rdy_g),
    .acc       (bus.m_g_tdata),
    .vld       (bus.m_g_tvalid),
    .m_tready  (bus.m_g_tready),
    .tlast_err (te_g)
  );

  data_lane_packer #(.DW_IN(DW_IN), .BEATS(H_BEATS)) u_lane_h (
    .clk       (clk),
    .rst       (rst),
    .beat_data (bus.s_in_tdata),
    .beat_we   (accept && dest == TDEST_H),
    .beat_last (bus.s_in_tlast),
    .ready     (rdy_h),
    .acc       (bus.m_h_tdata),
    .vld       (bus.m_h_tvalid),
    .m_tready  (bus.m_h_tready),
    .tlast_err (te_h)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_tdest <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      if (accept && dest == TDEST_BAD)
        err_tdest <= 1'b1;
      if (te_f || te_g || te_h)
        err_tlast <= 1'b1;
    end
  end

endmodule
